// File: rtl/lsu_queue_if.sv
// Bundle of issue, memory and write-back signals between the register manager,
// the data memory and the load/store queue. The queue connects as slave; the
// surrounding system (or a bench) drives the master side.
interface lsu_queue_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  // issue side
  logic            req_v_i;
  logic            req_ok_o;
  logic            op_store;
  logic [1:0]      op_size;
  logic            op_unsigned;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] immediate;
  logic [RD_W-1:0] rd_i;
  // data memory side
  logic            mem_r_v;
  logic            mem_w_v;
  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_data;
  logic [3:0]      mem_strobe;
  logic            mem_ready;
  logic            mem_res_v;
  logic [XLEN-1:0] mem_res;
  logic            mem_res_error;
  // write-back side
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_o;
  logic            result_v;
  logic            result_we;
  logic            exception;
  logic            ok_i;

  modport slave (
    input  req_v_i, op_store, op_size, op_unsigned, rs1, rs2, immediate, rd_i,
    input  mem_ready, mem_res_v, mem_res, mem_res_error, ok_i,
    output req_ok_o, mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    output result, rd_o, result_v, result_we, exception
  );

  modport master (
    output req_v_i, op_store, op_size, op_unsigned, rs1, rs2, immediate, rd_i,
    output mem_ready, mem_res_v, mem_res, mem_res_error, ok_i,
    input  req_ok_o, mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    input  result, rd_o, result_v, result_we, exception
  );
endinterface

// File: rtl/lsu_queue.sv
// In-order load/store queue. Requests go to memory combinationally in program
// order, up to DEPTH operations are tracked until their in-order responses
// arrive, and the oldest completed operation retires to write-back with its
// load data extracted and extended. Misaligned accesses are never sent to
// memory; they enter the queue already complete and flagged as faults.
module lsu_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input logic        clk,
  input logic        rst,
  lsu_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // queue control state
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] done_reg;
  logic [DEPTH-1:0] err_reg;

  // per-entry payload
  logic [RD_W-1:0]  rd_mem    [DEPTH];
  logic [1:0]       size_mem  [DEPTH];
  logic [1:0]       off_mem   [DEPTH];
  logic             uns_mem   [DEPTH];
  logic             store_mem [DEPTH];
  logic [XLEN-1:0]  data_mem  [DEPTH];

  // ---------------------------------------------------------------- issue
  logic [XLEN-1:0] adr;
  logic [1:0]      off;
  logic            is_byte;
  logic            is_half;
  logic            mis;
  logic            full;
  logic            push;
  logic [3:0]      strobe;
  logic [XLEN-1:0] store_data;

  assign adr     = bus.rs1 + bus.immediate;
  assign off     = adr[1:0];
  assign is_byte = (bus.op_size == 2'd0);
  assign is_half = (bus.op_size == 2'd1);
  // size 3 is treated as a word, so anything that is not byte/half needs off==0
  assign mis     = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'd0));
  assign full    = (count_reg == CNT_W'(DEPTH));

  // Lane placement of store bytes and their enables.
  always_comb begin
    strobe     = 4'b1111;
    store_data = bus.rs2;
    if (is_byte) begin
      strobe     = 4'b0001 << off;
      store_data = {(XLEN/8){bus.rs2[7:0]}};
    end else if (is_half) begin
      strobe     = 4'b0011 << off;
      store_data = {(XLEN/16){bus.rs2[15:0]}};
    end
  end

  assign bus.mem_r_v    = ~rst & bus.req_v_i & ~bus.op_store & ~mis & ~full;
  assign bus.mem_w_v    = ~rst & bus.req_v_i &  bus.op_store & ~mis & ~full;
  assign bus.req_ok_o   = ~rst & bus.req_v_i & ~full & (mis | bus.mem_ready);
  assign bus.mem_adr    = rst ? '0 : adr;
  assign bus.mem_data   = rst ? '0 : store_data;
  assign bus.mem_strobe = rst ? 4'b0000 : strobe;
  assign push           = bus.req_ok_o;

  // ------------------------------------------------------------- response
  logic             resp_found;
  logic [PTR_W-1:0] resp_idx;
  logic             resp_apply;

  // Oldest occupied entry still waiting for memory; misaligned entries are
  // already done and are skipped. Only registered state is searched, so a
  // response can never land on an entry pushed in the same cycle.
  always_comb begin
    resp_found = 1'b0;
    resp_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!resp_found && (CNT_W'(i) < count_reg) && !done_reg[head_reg + PTR_W'(i)]) begin
        resp_found = 1'b1;
        resp_idx   = head_reg + PTR_W'(i);
      end
    end
  end

  // A response with nothing pending (e.g. one that outlived a reset) is dropped.
  assign resp_apply = ~rst & bus.mem_res_v & resp_found;

  // --------------------------------------------------------------- retire
  logic [XLEN-1:0] head_shift;
  logic [XLEN-1:0] head_ext;
  logic            head_err;
  logic            head_store;
  logic            head_uns;
  logic            result_v;
  logic            pop;

  assign head_shift = data_mem[head_reg] >> {off_mem[head_reg], 3'b000};
  assign head_err   = err_reg[head_reg];
  assign head_store = store_mem[head_reg];
  assign head_uns   = uns_mem[head_reg];

  // Pick the addressed byte/half out of the response word and extend it.
  always_comb begin
    head_ext = data_mem[head_reg];
    case (size_mem[head_reg])
      2'd0:    head_ext = {{(XLEN-8){head_shift[7] & ~head_uns}}, head_shift[7:0]};
      2'd1:    head_ext = {{(XLEN-16){head_shift[15] & ~head_uns}}, head_shift[15:0]};
      default: head_ext = data_mem[head_reg];
    endcase
  end

  assign result_v      = ~rst & (count_reg != '0) & done_reg[head_reg];
  assign pop           = result_v & bus.ok_i;
  assign bus.result_v  = result_v;
  assign bus.result_we = result_v & ~head_store & ~head_err;
  assign bus.exception = result_v & head_err;
  assign bus.rd_o      = result_v ? rd_mem[head_reg] : '0;
  assign bus.result    = (result_v & ~head_store & ~head_err) ? head_ext : '0;

  // Pointers, occupancy and completion flags; reset discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      done_reg  <= '0;
      err_reg   <= '0;
    end else begin
      // push targets a free slot and the response an occupied one, so the
      // two writes to done/err never collide
      if (push) begin
        done_reg[tail_reg] <= mis;
        err_reg[tail_reg]  <= mis;
        tail_reg           <= tail_reg + 1'b1;
      end
      if (resp_apply) begin
        done_reg[resp_idx] <= 1'b1;
        err_reg[resp_idx]  <= bus.mem_res_error;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry payload capture; contents are only meaningful while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]    <= bus.rd_i;
      size_mem[tail_reg]  <= bus.op_size;
      off_mem[tail_reg]   <= off;
      uns_mem[tail_reg]   <= bus.op_unsigned;
      store_mem[tail_reg] <= bus.op_store;
    end
    if (resp_apply) begin
      data_mem[resp_idx] <= bus.mem_res;
    end
  end
endmodule

// File: doc/lsu_queue.md
Name: lsu_queue

Overview:
- Parametrised successor to the single-entry load/store stage.
- Issues loads and stores to the data memory in program order, with up to DEPTH operations outstanding.
- Aligns byte/half/word store data and strobes, and extracts and sign/zero-extends load data from a full-word response.
- Detects misaligned accesses without issuing them and retires every operation in order to write-back.

Parameters:
- XLEN, 32, data/address width (multiple of 32; strobes cover low word only).
- DEPTH, 4, outstanding-operation queue entries (power of 2, ≥2).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_v_i  in  1  issue valid from register manager
- req_ok_o  out  1  issue accepted this cycle
- op_store  in  1  1=store, 0=load
- op_size  in  2  0=byte, 1=half, 2=word (3 treated as word)
- op_unsigned  in  1  load zero-extends when 1
- rs1  in  XLEN  base address
- rs2  in  XLEN  store data
- immediate  in  XLEN  address offset
- rd_i  in  RD_W  load destination
- mem_r_v  out  1  read request
- mem_w_v  out  1  write request
- mem_adr  out  XLEN  request address
- mem_data  out  XLEN  lane-replicated store data
- mem_strobe  out  4  byte enables
- mem_ready  in  1  memory accepts request this cycle
- mem_res_v  in  1  response valid (loads: data; stores: ack)
- mem_res  in  XLEN  load response word
- mem_res_error  in  1  access fault with response
- result  out  XLEN  extended load data
- rd_o  out  RD_W  destination
- result_v  out  1  head operation retiring
- result_we  out  1  write register file
- exception  out  1  misaligned or memory fault
- ok_i  in  1  write-back accepts

Behaviour:
- Address: adr = rs1+immediate mod 2^XLEN; off = adr[1:0].
- Misaligned: half with off[0]=1; word with off≠0. No memory request is issued.
- Strobe: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
- mem_data: byte {rs2[7:0]}×4; half {rs2[15:0]}×2; word rs2.
- Request path is combinational (0 cycles):
  - mem_r_v = req_v_i & !op_store & !mis & !full.
  - mem_w_v = req_v_i & op_store & !mis & !full.
  - req_ok_o = req_v_i & !full & (mis | mem_ready).
  - mem_r_v/mem_w_v may assert while mem_ready=0; the request is taken only when req_ok_o=1.
- On accept, push entry {rd, size, unsigned, off, store, done=mis, err=mis}. Full when count==DEPTH; no push when full, even if a pop occurs the same cycle.
- Responses are in order:
  - resp_ptr = oldest entry with done=0.
  - mem_res_v writes data/error into that entry and sets done.
  - Responses apply only to entries already pushed, never the same-cycle push.
  - mem_res_v with no pending entry is dropped; the bench flags it as an error.
- Retire:
  - result_v = head valid & head.done; outputs are driven from head registers plus extraction.
  - Pop when result_v & ok_i; otherwise hold all outputs stable.
- Extraction: byte = data[8·off+:8]; half = data[8·off+:16]; extend per unsigned; word passes through.
- result_we = !store & !err. exception = err. result = 0 when err or store.
- Simultaneous push, response and pop in one cycle are all legal; count = count + push − pop.
- Earliest retire for an aligned op is the cycle after mem_res_v. A misaligned op at the head retires the cycle after its push.
- Reset: pointers and count cleared, all done bits cleared. All outputs reset to 0 (req_ok_o/mem_* follow inputs combinationally, gated low during rst). Reset mid-operation discards outstanding entries; later responses are dropped.
- Pointers wrap modulo DEPTH.

Test Plan:
- Byte load signed: rs1=0x100, imm=3, response 0x80000000 at cycle+2 -> strobe 1000, result 0xFFFFFF80, rd_o=rd_i, result_we=1.
- Half load unsigned: adr 0x102, response 0xBEEF0000 -> result 0x0000BEEF. Half store rs2=0x1234 at 0x102 -> mem_data 0x12341234, strobe 1100, retire with result_we=0.
- Misaligned word load: adr 0x101 -> mem_r_v=0, req_ok_o=1, retire next cycle with exception=1, result_we=0. Ordering holds behind an older pending load, which retires first.
- Back-to-back: issue DEPTH=4 loads with responses withheld -> req_ok_o=0 on the 5th. Respond to one and pop -> 5th accepted the next cycle; results come out in issue order.
- Back-pressure and faults: ok_i=0 for 3 cycles -> result/rd_o stable. mem_res_error=1 -> exception=1, result_we=0.
- Reset mid-flight: 2 loads outstanding, rst=1 for one cycle -> result_v=0 and count 0. A stale mem_res_v after reset -> no retire.
